// File: rtl/kia_scan_decoder.sv
// KIA queue Wishbone poller folding PS/2 set-2 E0/F0 prefixes into key events; optional bus timeout under PS2DEC_TIMEOUT_EN.
// Each byte costs STAT+DATA+POP bus cycles plus one decode cycle; a pending unaccepted event stalls polling (KIA queue backpressures).
module kia_scan_decoder #(
    parameter int unsigned POLL_GAP       = 4,
    parameter int unsigned TIMEOUT_CYCLES = 16
) (
    input  logic       CLK_I,
    input  logic       RES_I,
    output logic       CYC_O,
    output logic       STB_O,
    output logic       WE_O,
    output logic       ADR_O,
    output logic [7:0] DAT_O,
    input  logic [7:0] DAT_I,
    input  logic       ACK_I,
    output logic       EV_VALID_O,
    input  logic       EV_READY_I,
    output logic [7:0] EV_CODE_O,
    output logic       EV_BREAK_O,
    output logic       EV_EXT_O,
    output logic       ERR_O
);

    localparam int CW = $clog2(POLL_GAP + 2);

    typedef enum logic [2:0] {
        S_GAP,
        S_STAT,
        S_DATA,
        S_POP,
        S_TURN,
        S_DEC
    } state_t;

    state_t          state, state_nxt;
    state_t          after, after_nxt;
    logic [CW-1:0]   gap_cnt, gap_cnt_nxt;
    logic [7:0]      byte_q;
    logic            ext_q, brk_q;
    logic            in_bus;
    logic            bus_nxt;
    logic            timeout_hit;

    assign in_bus  = (state == S_STAT) || (state == S_DATA) || (state == S_POP);
    assign bus_nxt = (state_nxt == S_STAT) || (state_nxt == S_DATA) || (state_nxt == S_POP);
    assign DAT_O   = 8'h00;

    // TURN always follows a bus cycle; 'after' remembers where to go once the trailing ack has passed.
    always_comb begin
        state_nxt   = state;
        after_nxt   = after;
        gap_cnt_nxt = gap_cnt;
        case (state)
            S_GAP: begin
                if (gap_cnt > CW'(1)) begin
                    gap_cnt_nxt = gap_cnt - CW'(1);
                end else if (!EV_VALID_O) begin
                    state_nxt = S_STAT;
                end
            end
            S_STAT: begin
                if (ACK_I) begin
                    state_nxt = S_TURN;
                    if (DAT_I[0]) begin
                        after_nxt   = S_GAP;
                        gap_cnt_nxt = CW'(POLL_GAP);
                    end else begin
                        after_nxt = S_DATA;
                    end
                end
            end
            S_DATA: begin
                if (ACK_I) begin
                    state_nxt = S_TURN;
                    after_nxt = S_POP;
                end
            end
            S_POP: begin
                if (ACK_I) begin
                    state_nxt = S_TURN;
                    after_nxt = S_DEC;
                end
            end
            S_TURN: begin
                state_nxt = after;
            end
            S_DEC: begin
                state_nxt   = S_GAP;
                gap_cnt_nxt = '0;
            end
            default: begin
                state_nxt   = S_GAP;
                gap_cnt_nxt = CW'(POLL_GAP);
            end
        endcase
        if (timeout_hit) begin
            state_nxt   = S_TURN;
            after_nxt   = S_GAP;
            gap_cnt_nxt = CW'(POLL_GAP);
        end
    end

    always_ff @(posedge CLK_I) begin
        if (RES_I) begin
            state   <= S_GAP;
            after   <= S_GAP;
            gap_cnt <= CW'(POLL_GAP);
            CYC_O   <= 1'b0;
            STB_O   <= 1'b0;
            WE_O    <= 1'b0;
            ADR_O   <= 1'b0;
        end else begin
            state   <= state_nxt;
            after   <= after_nxt;
            gap_cnt <= gap_cnt_nxt;
            CYC_O   <= bus_nxt;
            STB_O   <= bus_nxt;
            WE_O    <= (state_nxt == S_POP);
            ADR_O   <= (state_nxt == S_DATA) || (state_nxt == S_POP);
        end
    end

    always_ff @(posedge CLK_I) begin
        if (RES_I) begin
            byte_q     <= 8'h00;
            ext_q      <= 1'b0;
            brk_q      <= 1'b0;
            EV_VALID_O <= 1'b0;
            EV_CODE_O  <= 8'h00;
            EV_EXT_O   <= 1'b0;
            EV_BREAK_O <= 1'b0;
        end else begin
            if (EV_VALID_O && EV_READY_I) begin
                EV_VALID_O <= 1'b0;
            end
            if ((state == S_DATA) && ACK_I) begin
                byte_q <= DAT_I;
            end
            if (timeout_hit) begin
                ext_q <= 1'b0;
                brk_q <= 1'b0;
            end else if (state == S_DEC) begin
                // Polling is held off while an event is pending, so DEC never overwrites one.
                if (byte_q == 8'hE0) begin
                    ext_q <= 1'b1;
                end else if (byte_q == 8'hF0) begin
                    brk_q <= 1'b1;
                end else begin
                    EV_CODE_O  <= byte_q;
                    EV_EXT_O   <= ext_q;
                    EV_BREAK_O <= brk_q;
                    EV_VALID_O <= 1'b1;
                    ext_q      <= 1'b0;
                    brk_q      <= 1'b0;
                end
            end
        end
    end

`ifdef PS2DEC_TIMEOUT_EN
    localparam int TW = $clog2(TIMEOUT_CYCLES + 1);

    logic [TW-1:0] to_cnt;
    logic          err_q;

    assign timeout_hit = in_bus && !ACK_I && (to_cnt == TW'(TIMEOUT_CYCLES - 1));
    assign ERR_O       = err_q;

    always_ff @(posedge CLK_I) begin
        if (RES_I) begin
            to_cnt <= '0;
            err_q  <= 1'b0;
        end else begin
            if (in_bus && !ACK_I && !timeout_hit) begin
                to_cnt <= to_cnt + TW'(1);
            end else begin
                to_cnt <= '0;
            end
            if (timeout_hit) begin
                err_q <= 1'b1;
            end
        end
    end
`else
    assign timeout_hit = 1'b0;
    assign ERR_O       = 1'b0;
`endif

endmodule
